seg7_capture_encoder: RTL and testbench

- Reverse direction of the common-anode BCD-to-7-segment path: watches active-low segment lines (a..g) and encodes each settled digit pattern back to a 4-bit BCD code.
- Filters glitches with a stability window and issues exactly one capture per settled pattern.
- Captures are delivered over a valid/ready handshake with a one-entry output buffer.
- Sits between a display bus (or display model) and a checker or processor that needs the displayed digit value.

---
 rtl/seg7_capture_encoder.sv | 145 ++++++++++++++
 tb/tb_seg7_capture_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture_encoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | seg7_capture_encoder: debounces active-low 7-segment lines and encodes    |
// | each settled digit to BCD over a one-entry valid/ready buffer.            |
// | Optional hex letters A..F via macro SEG7_HEX_EN.  Rev 1.0                 |
// +---------------------------------------------------------------------------+
module seg7_capture_encoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] bcd_out,
  output logic       err,
  output logic       ovf,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [6:0]       C_BLANK  = 7'h7F;
  localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       s_q;
  logic [6:0]       pat_q, pat_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             cap;
  logic [4:0]       dec;

  // Returns {err, bcd}; anything not recognised maps to {1, 4'hF}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = 5'h00;
      7'h79:   decode = 5'h01;
      7'h24:   decode = 5'h02;
      7'h30:   decode = 5'h03;
      7'h19:   decode = 5'h04;
      7'h12:   decode = 5'h05;
      7'h02:   decode = 5'h06;
      7'h78:   decode = 5'h07;
      7'h00:   decode = 5'h08;
      7'h10:   decode = 5'h09;
`ifdef SEG7_HEX_EN
      7'h08:   decode = 5'h0A;
      7'h03:   decode = 5'h0B;
      7'h46:   decode = 5'h0C;
      7'h21:   decode = 5'h0D;
      7'h06:   decode = 5'h0E;
      7'h0E:   decode = 5'h0F;
`endif
      default: decode = 5'h1F;
    endcase
  endfunction

  assign dec = decode(s_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    cap     = 1'b0;
    if (s_q == C_BLANK) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE || s_q != pat_q) begin
      // A fresh pattern has already been seen for one cycle.
      pat_d = s_q;
      cnt_d = C_ONE;
      if (C_ONE == C_STABLE) begin
        cap     = 1'b1;
        state_d = HOLD;
      end else begin
        state_d = SETTLE;
      end
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + C_ONE;
      if (cnt_d == C_STABLE) begin
        cap     = 1'b1;
        state_d = HOLD;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    bcd_d       = bcd_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    if (cap) begin
      // A transfer on the same edge frees the buffer for the new capture.
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        bcd_d       = dec[3:0];
        err_d       = dec[4];
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= C_BLANK;
      pat_q       <= C_BLANK;
      out_valid_q <= 1'b0;
      bcd_q       <= 4'h0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= seg_n;
      pat_q       <= pat_d;
      out_valid_q <= out_valid_d;
      bcd_q       <= bcd_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_encoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_seg7_capture_encoder: scoreboard bench with a run-length reference     |
// | model of the capture rule and buffer.  Rev 1.0                            |
// +---------------------------------------------------------------------------+
module tb_seg7_capture_encoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_n = 7'h7F;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] bcd_out;
  logic       err;
  logic       ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seg7_capture_encoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_n     (seg_n),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .err       (err),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [6:0] digit_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] hex_codes   [6]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == p) r = {1'b0, 4'(i)};
`ifdef SEG7_HEX_EN
    for (int i = 0; i < 6; i++)
      if (hex_codes[i] == p) r = {1'b0, 4'(10 + i)};
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pattern is captured on the edge where it has been
  // seen in the sampled register for exactly STABLE consecutive cycles.
  logic [6:0] m_s, m_last;
  int         m_run;
  logic       m_valid, m_ovf, m_busy;
  logic [4:0] exp_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s = 7'h7F; m_last = 7'h7F; m_run = 0;
      m_valid = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
      exp_q.delete();
    end else begin
      logic [6:0] p;
      logic       cap;
      p = m_s;
      if (p == m_last) m_run++;
      else m_run = 1;
      m_last = p;
      cap    = (p != 7'h7F) && (m_run == STABLE);
      m_busy = (p != 7'h7F);
      if (cap) begin
        if (!m_valid || out_ready) begin
          exp_q.push_back(ref_decode(p));
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      m_s = seg_n;
    end
  end

  // Monitor: compares on the falling edge, pops on an accepted transfer.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_busy));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("capture_expected", 32'(1), 32'(0));
        end else begin
          check("capture_data", 32'({err, bcd_out}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [6:0] s, input logic r, input int n);
    seg_n     = s;
    out_ready = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] pat;
    int         kind, len;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'(0));
    check("reset_bcd", 32'(bcd_out), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    drive(7'h7F, 1'b1, 3);

    // Basic capture of digit 3.
    drive(7'h30, 1'b1, 10);
    drive(7'h7F, 1'b1, 3);
    // Glitch filter: 2 held too briefly, then 5.
    drive(7'h24, 1'b1, 3);
    drive(7'h12, 1'b1, 8);
    drive(7'h7F, 1'b1, 3);
    // Letter A: legal only with hex support.
    drive(7'h08, 1'b1, 8);
    drive(7'h7F, 1'b1, 3);
    // Repeat of 8 with ready pulsed on the second capture edge.
    drive(7'h00, 1'b0, 6);
    drive(7'h7F, 1'b0, 1);
    drive(7'h00, 1'b0, 4);
    drive(7'h00, 1'b1, 1);
    check("no_ovf_on_simultaneous", 32'(ovf), 32'(0));
    drive(7'h00, 1'b0, 3);
    drive(7'h7F, 1'b1, 3);
    // Backpressure: 7 is held, 9 is dropped.
    drive(7'h78, 1'b0, 6);
    drive(7'h7F, 1'b0, 2);
    drive(7'h10, 1'b0, 6);
    check("bp_bcd", 32'(bcd_out), 32'(7));
    check("bp_ovf", 32'(ovf), 32'(1));
    drive(7'h10, 1'b1, 1);
    drive(7'h7F, 1'b1, 3);

    // Reset while a capture is pending and the FSM is settling.
    drive(7'h30, 1'b0, 6);
    drive(7'h24, 1'b0, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'(0));
    check("arst_bcd_err", 32'({err, bcd_out}), 32'(0));
    check("arst_ovf", 32'(ovf), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    seg_n = 7'h7F;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(7'h7F, 1'b1, 6);

    // Randomised patterns with random backpressure.
    pat = 7'h7F;
    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1:       pat = 7'h7F;
        2, 3, 4, 5: pat = digit_codes[$urandom_range(0, 9)];
        6, 7:       pat = hex_codes[$urandom_range(0, 5)];
        8:          pat = 7'($urandom);
        default:    pat = pat;
      endcase
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++)
        drive(pat, 1'($urandom_range(0, 2) != 0), 1);
    end

    drive(7'h7F, 1'b1, 6);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
